// File: rtl/iddmm_row_acc.sv
// iddmm_row_acc: carry-propagating accumulator for one schoolbook row of 256-bit partial products.
// Emits K+1 128-bit words through a ready/valid FIFO; define IDDMM_ACC_ADDEND_EN to add c_in per word.
module iddmm_row_acc #(
   parameter int FIFO_DEPTH    = 16,
   parameter int CREDIT_MARGIN = 12,
   parameter int IDX_W         = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             prod_valid,
   input  logic [255:0]     prod,
   input  logic             prod_first,
   input  logic             prod_last,
`ifdef IDDMM_ACC_ADDEND_EN
   input  logic [127:0]     c_in,
`endif
   output logic             prod_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_word,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             ovf_err,
   output logic             row_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {IDLE, ROW} state_t;
   state_t state, state_nx;
   logic [127:0] carry, addend;
   logic [127:0] mem_word [FIFO_DEPTH];
   logic [IDX_W-1:0] mem_idx [FIFO_DEPTH];
   logic mem_last [FIFO_DEPTH];
   logic [IDX_W-1:0] idx, widx, widx1;
   logic [AW-1:0] wp, wp1, rp;
   logic [CW-1:0] count, count_nx;
   logic [CW:0] free;
   logic [255:0] sum;
   logic [1:0] nw;
   logic acc, drop, restart, wrap, rd, wr_ok;
`ifdef IDDMM_ACC_ADDEND_EN
   assign addend = c_in;
`else
   assign addend = '0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb state_nx = acc ? (prod_last ? IDLE : ROW) : state;
   always_comb begin
      acc      = prod_valid & (prod_first | state == ROW);
      drop     = prod_valid & ~prod_first & state == IDLE;
      restart  = prod_valid & prod_first & state == ROW;
      widx     = prod_first ? '0 : idx;
      widx1    = widx + IDX_W'(1);
      wrap     = acc & (&widx);
      sum      = prod + {128'b0, addend} + {128'b0, prod_first ? 128'b0 : carry};
      out_valid = count != '0;
      rd       = out_valid & out_ready;
      nw       = acc ? (prod_last ? 2'd2 : 2'd1) : 2'd0;
      // the slot freed by a same-cycle read is usable by this cycle's writes
      free     = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + (CW+1)'(rd);
      wr_ok    = (CW+1)'(nw) <= free;
      count_nx = count + CW'(wr_ok ? nw : 2'd0) - CW'(rd);
      wp1      = wp + AW'(1);
      out_word = out_valid ? mem_word[rp] : '0;
      out_idx  = out_valid ? mem_idx[rp] : '0;
      out_last = out_valid & mem_last[rp];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         carry      <= '0;
         idx        <= '0;
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
         prod_ready <= 1'b1;
         ovf_err    <= 1'b0;
         row_err    <= 1'b0;
      end else begin
         if (acc) begin
            carry <= prod_last ? '0 : sum[255:128];
            idx   <= prod_last ? '0 : widx1;
         end
         if (acc & wr_ok) wp <= wp + AW'(nw);
         if (rd) rp <= rp + AW'(1);
         count      <= count_nx;
         prod_ready <= ((CW+1)'(FIFO_DEPTH) - {1'b0, count_nx}) >= (CW+1)'(CREDIT_MARGIN);
         if (acc & ~wr_ok) ovf_err <= 1'b1;
         if (drop | restart | wrap) row_err <= 1'b1;
      end
   always_ff @(posedge clk)
      if (acc & wr_ok) begin
         mem_word[wp] <= sum[127:0];
         mem_idx[wp]  <= widx;
         mem_last[wp] <= 1'b0;
         if (prod_last) begin
            mem_word[wp1] <= sum[255:128];
            mem_idx[wp1]  <= widx1;
            mem_last[wp1] <= 1'b1;
         end
      end
endmodule
